psum_accumulator: RTL

- Downstream of the systolic array. Consumes the ARRAY_SIZE-wide 52-bit partial-sum row from the bottom of the array.
- Accumulates that row across a programmable number of passes, e.g. K-dimension tiles or bit-serial fusion passes.
- Then drains the per-column totals one column per beat over a valid/ready stream to the writeback/output buffer.

---
 rtl/psum_accumulator.sv | 138 +++++++++++++
 1 files changed

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - accumulates systolic-array psum rows over N passes, drains per-column totals.
module psum_accumulator #(
    parameter int ARRAY_SIZE = 8,
    parameter int PSUM_WIDTH = 52,
    parameter int ACC_WIDTH  = 64,
    parameter int PASS_W     = 8,
    localparam int COL_W     = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [PASS_W-1:0]                    num_passes,
    input  logic                                 s_psum,
    input  logic                                 psum_valid,
    output logic                                 psum_ready,
    input  logic [ARRAY_SIZE-1:0][PSUM_WIDTH-1:0] psums,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ACC_WIDTH-1:0]                 out_data,
    output logic [COL_W-1:0]                     out_col,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 overflow
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q [ARRAY_SIZE];
    logic [ACC_WIDTH-1:0]   acc_d [ARRAY_SIZE];
    logic [PASS_W-1:0]      pass_q, pass_d;
    logic [PASS_W-1:0]      np_q, np_d;
    logic                   sgn_q, sgn_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic                   ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0]   ext_w [ARRAY_SIZE];
    logic [ACC_WIDTH:0]     sum_w [ARRAY_SIZE];
    logic                   ovf_any;
    logic                   beat;
    logic                   last_beat;
    logic                   last_col;
    logic                   hs;

    assign beat      = (state_q == ACCUM) && psum_valid;
    assign last_beat = beat && ((pass_q + PASS_W'(1)) == np_q);
    assign last_col  = (col_q == COL_W'(ARRAY_SIZE - 1));
    assign hs        = (state_q == DRAIN) && out_ready;

    // One extra bit on each sum carries the unsigned carry-out for overflow detection.
    always_comb begin
        ovf_any = 1'b0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            ext_w[i] = sgn_q ? ACC_WIDTH'($signed(psums[i])) : ACC_WIDTH'(psums[i]);
            sum_w[i] = {1'b0, acc_q[i]} + {1'b0, ext_w[i]};
            if (sgn_q) begin
                ovf_any = ovf_any
                        | ((acc_q[i][ACC_WIDTH-1] == ext_w[i][ACC_WIDTH-1])
                        && (sum_w[i][ACC_WIDTH-1] != acc_q[i][ACC_WIDTH-1]));
            end else begin
                ovf_any = ovf_any | sum_w[i][ACC_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)            state_d = ACCUM;
            ACCUM:   if (last_beat)        state_d = DRAIN;
            DRAIN:   if (hs && last_col)   state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    always_comb begin
        psum_ready = (state_q == ACCUM);
        out_valid  = (state_q == DRAIN);
        out_data   = (state_q == DRAIN) ? acc_q[col_q] : '0;
        out_col    = col_q;
        out_last   = (state_q == DRAIN) && last_col;
        busy       = (state_q != IDLE);
        overflow   = ovf_q;
    end

    always_comb begin
        acc_d  = acc_q;
        pass_d = pass_q;
        np_d   = np_q;
        sgn_d  = sgn_q;
        col_d  = col_q;
        ovf_d  = ovf_q;
        if ((state_q == IDLE) && start) begin
            np_d   = (num_passes == '0) ? PASS_W'(1) : num_passes;
            sgn_d  = s_psum;
            pass_d = '0;
            col_d  = '0;
            ovf_d  = 1'b0;
            for (int i = 0; i < ARRAY_SIZE; i++) acc_d[i] = '0;
        end
        if (beat) begin
            for (int i = 0; i < ARRAY_SIZE; i++) acc_d[i] = sum_w[i][ACC_WIDTH-1:0];
            ovf_d  = ovf_q | ovf_any;
            pass_d = pass_q + PASS_W'(1);
            if (last_beat) col_d = '0;
        end
        if (hs) begin
            col_d = last_col ? '0 : col_q + COL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARRAY_SIZE; i++) acc_q[i] <= '0;
            pass_q <= '0;
            np_q   <= '0;
            sgn_q  <= 1'b0;
            col_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            for (int i = 0; i < ARRAY_SIZE; i++) acc_q[i] <= acc_d[i];
            pass_q <= pass_d;
            np_q   <= np_d;
            sgn_q  <= sgn_d;
            col_q  <= col_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule
